imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder_if.sv | 26 ++
 rtl/imem_responder.sv | 111 +++++++++++
 tb/tb_imem_responder.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_responder_if.sv
// Instruction-fetch bus between a fetch initiator and the instruction memory
// responder: request/response handshake, redirect flush and program-load port.
interface imem_responder_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic [31:0] rsp_addr;
  logic        rsp_err;
  logic        flush;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  modport master (
    output req_valid, req_addr, rsp_ready, flush, load_en, load_addr, load_data,
    input  req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, flush, load_en, load_addr, load_data,
    output req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_err
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory responder: one outstanding fetch at a time, fixed
// LATENCY wait cycles, misaligned/out-of-range fetches answered with a NOP
// and an error flag, flush abandons the outstanding fetch.
module imem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic              i_clk,
  input logic              i_rst,
  imem_responder_if.slave  bus
);

  localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        rsp_valid;
  logic [31:0] rsp_inst;
  logic [31:0] rsp_addr;
  logic        rsp_err;
  logic [31:0] mem [DEPTH_WORDS];

  // Byte offset of the load address plays no part in word writes.
  logic unused_load_lsbs;
  assign unused_load_lsbs = ^bus.load_addr[1:0];

  // Word index lies inside the storage when every bit above it is zero.
  function automatic logic in_range(input logic [31:0] a);
    return (a[31:AW+2] == '0);
  endfunction

  function automatic logic fetch_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || !in_range(a);
  endfunction

  // Reads the array as it stood before this edge's load, so a colliding
  // load is not visible to the response being captured.
  function automatic logic [31:0] fetch_word(input logic [31:0] a);
    return fetch_err(a) ? NOP : mem[a[AW+1:2]];
  endfunction

  assign bus.req_ready = (state == IDLE) && !bus.flush && !i_rst;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_inst  = rsp_inst;
  assign bus.rsp_addr  = rsp_addr;
  assign bus.rsp_err   = rsp_err;

  // Program-load write port; independent of the fetch state machine.
  always_ff @(posedge i_clk) begin
    if (bus.load_en && in_range(bus.load_addr)) begin
      mem[bus.load_addr[AW+1:2]] <= bus.load_data;
    end
  end

  // Fetch state machine with registered response outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_inst  <= 32'd0;
      rsp_addr  <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && !bus.flush) begin
            rsp_addr <= bus.req_addr;
            if (LATENCY == 0) begin
              rsp_inst  <= fetch_word(bus.req_addr);
              rsp_err   <= fetch_err(bus.req_addr);
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              cnt   <= CNT_INIT;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.flush) begin
            cnt   <= 4'd0;
            state <= IDLE;
          end else if (cnt == 4'd0) begin
            rsp_inst  <= fetch_word(rsp_addr);
            rsp_err   <= fetch_err(rsp_addr);
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.flush || bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: a LATENCY=2 instance exercised with a table of
// fetches, directed stall/flush/reset/collision sequences and random traffic
// against a word-array reference model, plus a LATENCY=0 instance for
// back-to-back fetches.
module tb_imem_responder;

  localparam int          DEPTH = 64;
  localparam int          LAT   = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_responder_if bus0 ();
  imem_responder_if bus1 ();

  imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut0 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus0.slave)
  );

  imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus1.slave)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] ref_mem [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: what a fetch of byte address a must return.
  function automatic void model(input logic [31:0] a, output logic [31:0] inst, output logic err);
    err  = (a % 4 != 0) || ((a / 4) >= 32'(DEPTH));
    inst = err ? NOP : ref_mem[a / 4];
  endfunction

  // Writes the same word into both instances and the reference array.
  task automatic load(input logic [31:0] a, input logic [31:0] d);
    bus0.load_en = 1'b1; bus0.load_addr = a; bus0.load_data = d;
    bus1.load_en = 1'b1; bus1.load_addr = a; bus1.load_data = d;
    tick();
    bus0.load_en = 1'b0;
    bus1.load_en = 1'b0;
    if ((a / 4) < 32'(DEPTH)) ref_mem[a / 4] = d;
  endtask

  // Full fetch on the LATENCY=2 instance with an optional response stall.
  task automatic fetch0(input logic [31:0] a, input int stall, input string tag);
    logic [31:0] exp_inst, ci, ca;
    logic        exp_err, ce;
    int          lat, w;
    model(a, exp_inst, exp_err);
    w = 0;
    while (bus0.req_ready !== 1'b1 && w < 20) begin tick(); w++; end
    chk({tag, " req_ready"}, {31'b0, bus0.req_ready}, 32'd1);
    bus0.req_valid = 1'b1;
    bus0.req_addr  = a;
    tick();
    bus0.req_valid = 1'b0;
    bus0.req_addr  = $urandom;
    lat = 0;
    while (bus0.rsp_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
    chk({tag, " latency"}, 32'(lat), 32'(LAT));
    if (bus0.rsp_valid !== 1'b1) return;
    chk({tag, " inst"}, bus0.rsp_inst, exp_inst);
    chk({tag, " err"},  {31'b0, bus0.rsp_err}, {31'b0, exp_err});
    chk({tag, " addr"}, bus0.rsp_addr, a);
    ci = bus0.rsp_inst; ca = bus0.rsp_addr; ce = bus0.rsp_err;
    for (int s = 0; s < stall; s++) begin
      tick();
      chk({tag, " stall valid"}, {31'b0, bus0.rsp_valid}, 32'd1);
      chk({tag, " stall ready"}, {31'b0, bus0.req_ready}, 32'd0);
      chk({tag, " stall inst"},  bus0.rsp_inst, ci);
      chk({tag, " stall addr"},  bus0.rsp_addr, ca);
      chk({tag, " stall err"},   {31'b0, bus0.rsp_err}, {31'b0, ce});
    end
    bus0.rsp_ready = 1'b1;
    tick();
    bus0.rsp_ready = 1'b0;
    chk({tag, " done valid"}, {31'b0, bus0.rsp_valid}, 32'd0);
    chk({tag, " done ready"}, {31'b0, bus0.req_ready}, 32'd1);
  endtask

  vec_t        tbl [7];
  logic [31:0] old_w, ra;

  initial begin
    bus0.req_valid = 0; bus0.req_addr = 0; bus0.rsp_ready = 0; bus0.flush = 0;
    bus0.load_en = 0; bus0.load_addr = 0; bus0.load_data = 0;
    bus1.req_valid = 0; bus1.req_addr = 0; bus1.rsp_ready = 0; bus1.flush = 0;
    bus1.load_en = 0; bus1.load_addr = 0; bus1.load_data = 0;

    // Reset state, ready held low while reset is asserted
    rst = 1'b1;
    tick(); tick();
    chk("rst req_ready", {31'b0, bus0.req_ready}, 32'd0);
    chk("rst rsp_valid", {31'b0, bus0.rsp_valid}, 32'd0);
    chk("rst rsp_inst",  bus0.rsp_inst, 32'd0);
    chk("rst rsp_addr",  bus0.rsp_addr, 32'd0);
    chk("rst rsp_err",   {31'b0, bus0.rsp_err}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post-rst req_ready", {31'b0, bus0.req_ready}, 32'd1);

    for (int i = 0; i < DEPTH; i++) load(32'(i * 4), 32'hC0DE_0000 + 32'(i * 17));
    load(32'h0000_0000, 32'h0050_0093);
    load(32'h0000_0004, 32'h0010_0113);
    load(32'h0000_0020, 32'h0020_81B3);
    load(32'h0000_00FC, 32'h7FF0_0067);

    // Table of single fetches with fixed expected words
    tbl[0] = '{32'h0000_0000, 32'h0050_0093, 1'b0};
    tbl[1] = '{32'h0000_0004, 32'h0010_0113, 1'b0};
    tbl[2] = '{32'h0000_0020, 32'h0020_81B3, 1'b0};
    tbl[3] = '{32'h0000_00FC, 32'h7FF0_0067, 1'b0};
    tbl[4] = '{32'h0000_0006, NOP,           1'b1};
    tbl[5] = '{32'h0000_0100, NOP,           1'b1};
    tbl[6] = '{32'hFFFF_FFFC, NOP,           1'b1};
    for (int i = 0; i < 7; i++) begin
      logic [31:0] mi;
      logic        me;
      model(tbl[i].addr, mi, me);
      chk($sformatf("tbl%0d model inst", i), mi, tbl[i].inst);
      fetch0(tbl[i].addr, 0, $sformatf("tbl%0d", i));
    end

    // Response held under back-pressure for 5 cycles
    fetch0(32'h0000_0004, 5, "stall5");

    // Flush one cycle after accept: no response, next fetch served
    bus0.req_valid = 1'b1; bus0.req_addr = 32'h10;
    tick();
    bus0.req_valid = 1'b0; bus0.flush = 1'b1;
    #1 chk("flush wait ready", {31'b0, bus0.req_ready}, 32'd0);
    tick();
    bus0.flush = 1'b0;
    for (int c = 0; c < LAT + 4; c++) begin
      chk("flush wait no rsp", {31'b0, bus0.rsp_valid}, 32'd0);
      tick();
    end
    fetch0(32'h0000_0020, 0, "after flush");

    // Flush beats rsp_ready while the response is held
    bus0.req_valid = 1'b1; bus0.req_addr = 32'h0;
    tick();
    bus0.req_valid = 1'b0;
    for (int c = 0; c < LAT; c++) tick();
    chk("flush resp valid before", {31'b0, bus0.rsp_valid}, 32'd1);
    bus0.flush = 1'b1; bus0.rsp_ready = 1'b1;
    tick();
    bus0.flush = 1'b0; bus0.rsp_ready = 1'b0;
    chk("flush resp valid after", {31'b0, bus0.rsp_valid}, 32'd0);

    // Flush in IDLE blocks the accept
    bus0.req_valid = 1'b1; bus0.req_addr = 32'h4; bus0.flush = 1'b1;
    #1 chk("idle flush ready", {31'b0, bus0.req_ready}, 32'd0);
    tick();
    bus0.req_valid = 1'b0; bus0.flush = 1'b0;
    for (int c = 0; c < LAT + 3; c++) begin
      chk("idle flush no rsp", {31'b0, bus0.rsp_valid}, 32'd0);
      tick();
    end

    // Reset during WAIT discards the fetch; memory survives reset
    bus0.req_valid = 1'b1; bus0.req_addr = 32'h0;
    tick();
    bus0.req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < LAT + 3; c++) begin
      chk("rst wait no rsp", {31'b0, bus0.rsp_valid}, 32'd0);
      tick();
    end
    fetch0(32'h0000_0000, 0, "after rst");

    // Load colliding with the capture edge returns the old word
    old_w = ref_mem[2];
    bus0.req_valid = 1'b1; bus0.req_addr = 32'h8;
    tick();
    bus0.req_valid = 1'b0;
    for (int c = 0; c < LAT - 1; c++) tick();
    bus0.load_en = 1'b1; bus0.load_addr = 32'h8; bus0.load_data = 32'hABCD_1234;
    tick();
    bus0.load_en = 1'b0;
    chk("collide valid", {31'b0, bus0.rsp_valid}, 32'd1);
    chk("collide old word", bus0.rsp_inst, old_w);
    bus0.rsp_ready = 1'b1;
    tick();
    bus0.rsp_ready = 1'b0;
    load(32'h8, 32'hABCD_1234);
    fetch0(32'h0000_0008, 0, "collide new word");

    // Out-of-range load must not alias onto a stored word
    load(32'(DEPTH * 4), 32'hBAD0_BAD0);
    fetch0(32'h0000_0000, 0, "oor load");

    // LATENCY=0 instance: back-to-back fetches, one response every 2 cycles
    bus1.rsp_ready = 1'b1; bus1.req_valid = 1'b1; bus1.req_addr = 32'h0;
    tick();
    chk("lat0 rsp0 valid", {31'b0, bus1.rsp_valid}, 32'd1);
    chk("lat0 rsp0 inst",  bus1.rsp_inst, ref_mem[0]);
    bus1.req_addr = 32'h4;
    tick();
    chk("lat0 gap valid", {31'b0, bus1.rsp_valid}, 32'd0);
    chk("lat0 gap ready", {31'b0, bus1.req_ready}, 32'd1);
    tick();
    chk("lat0 rsp1 valid", {31'b0, bus1.rsp_valid}, 32'd1);
    chk("lat0 rsp1 inst",  bus1.rsp_inst, ref_mem[1]);
    chk("lat0 rsp1 addr",  bus1.rsp_addr, 32'h4);
    bus1.req_valid = 1'b0;
    tick();
    chk("lat0 end valid", {31'b0, bus1.rsp_valid}, 32'd0);
    bus1.rsp_ready = 1'b0;

    // Random loads and fetches against the reference array
    for (int it = 0; it < 150; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3) begin
        ra = (r == 0) ? 32'($urandom) : {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
        load(ra, $urandom);
      end else begin
        ra = ($urandom_range(0, 7) == 0) ? 32'($urandom)
                                         : {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
        fetch0(ra, $urandom_range(0, 3), "rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
